mul_iter_unit: RTL and testbench

//  Parametrised iterative RV32M multiplier functional unit: MUL/MULH/MULHSU/MULHU, BITS_PER_CYCLE multiplier

---
 rtl/mul_iter_unit_pkg.sv | 28 ++
 rtl/mul_iter_unit_radix_step.sv | 20 ++
 rtl/mul_iter_unit.sv | 173 +++++++++++++++++
 tb/tb_mul_iter_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_iter_unit_pkg.sv
// Shared types for the iterative multiplier: operation encoding, CDB packet and tag widths.
package mul_iter_unit_pkg;

  localparam int XLEN      = 32;
  localparam int PR_WIDTH  = 6;
  localparam int ROB_WIDTH = 4;

  // Encoding matches funct3[1:0] of the RV32M multiply group.
  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  typedef struct packed {
    logic                 cdb_valid;
    logic [ROB_WIDTH-1:0] rob;
    logic [4:0]           arch_reg;
    logic [PR_WIDTH-1:0]  phys_reg;
    logic [XLEN-1:0]      data;
    logic [XLEN-1:0]      ps1_rdata;
    logic [XLEN-1:0]      ps2_rdata;
    logic                 br_taken;
    logic [XLEN-1:0]      br_target;
  } cdb_t;

endpackage

// File: rtl/mul_iter_unit_radix_step.sv
// One radix-2^BPC partial-product step: acc_out = acc_in + (mag_a * digit) << shift, all unsigned.
module mul_radix_step #(
  parameter int ACC_W   = 64,
  parameter int MAG_W   = 32,
  parameter int DIGIT_W = 2,
  parameter int SHIFT_W = 6
) (
  input  logic [ACC_W-1:0]   acc_in,
  input  logic [MAG_W-1:0]   mag_a,
  input  logic [DIGIT_W-1:0] digit,
  input  logic [SHIFT_W-1:0] shift,
  output logic [ACC_W-1:0]   acc_out
);

  logic [ACC_W-1:0] partial;

  assign partial = ACC_W'(mag_a) * ACC_W'(digit);
  assign acc_out = acc_in + (partial << shift);

endmodule

// File: rtl/mul_iter_unit.sv
// Iterative RV32M multiplier: sign-magnitude shift-add over BITS_PER_CYCLE multiplier bits per cycle,
// result held on the CDB until acknowledged, killed by flush.
module mul_iter_unit
  import mul_iter_unit_pkg::*;
#(
  parameter int OPERAND_WIDTH  = 32,
  parameter int BITS_PER_CYCLE = 2,
  parameter int EARLY_TERM     = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [1:0]               mul_op,
  input  logic [OPERAND_WIDTH-1:0] a,
  input  logic [OPERAND_WIDTH-1:0] b,
  input  logic [4:0]               arch_reg,
  input  logic [PR_WIDTH-1:0]      phys_reg,
  input  logic [ROB_WIDTH-1:0]     rob,
  input  logic                     flush,
  input  logic                     cdb_mul_ack,
  output cdb_t                     mul_cdb_output
);

  localparam int W   = OPERAND_WIDTH;
  localparam int BPC = BITS_PER_CYCLE;
  localparam int N   = W / BPC;
  localparam int CW  = $clog2(N) + 1;
  localparam int SW  = $clog2(2 * W);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  function automatic logic [W-1:0] mag_of(input logic [W-1:0] x, input logic sgn);
    return sgn ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*W-1:0] neg2w(input logic [2*W-1:0] x);
    return ~x + 1'b1;
  endfunction

  logic [1:0]           state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [ROB_WIDTH-1:0] rob_q, rob_d;
  logic [4:0]           arch_q, arch_d;
  logic [PR_WIDTH-1:0]  phys_q, phys_d;
  logic [W-1:0]         ps1_q, ps1_d, ps2_q, ps2_d;
  logic [W-1:0]         mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic [2*W-1:0]       acc_q, acc_d;
  logic                 neg_q, neg_d;
  logic [CW-1:0]        iter_q, iter_d;

  logic [2*W-1:0] acc_step;
  logic [SW-1:0]  shift;
  logic [W-1:0]   mag_b_shift;
  logic           last_iter, accept, sign_a, sign_b;

  assign shift = SW'(iter_q * BPC);

  mul_radix_step #(
    .ACC_W   (2 * W),
    .MAG_W   (W),
    .DIGIT_W (BPC),
    .SHIFT_W (SW)
  ) u_step (
    .acc_in  (acc_q),
    .mag_a   (mag_a_q),
    .digit   (mag_b_q[BPC-1:0]),
    .shift   (shift),
    .acc_out (acc_step)
  );

  always_comb begin
    start_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & cdb_mul_ack);
    accept      = start_valid & start_ready & ~flush;
    sign_a      = a[W-1] & ((mul_op == MULH) | (mul_op == MULHSU));
    sign_b      = b[W-1] & (mul_op == MULH);
    mag_b_shift = mag_b_q >> BPC;
    last_iter   = (iter_q == CW'(N - 1)) | ((EARLY_TERM != 0) & (mag_b_shift == '0));

    state_d = state_q;
    op_d    = op_q;
    rob_d   = rob_q;
    arch_d  = arch_q;
    phys_d  = phys_q;
    ps1_d   = ps1_q;
    ps2_d   = ps2_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    iter_d  = iter_q;

    case (state_q)
      S_BUSY: begin
        acc_d   = acc_step;
        mag_b_d = mag_b_shift;
        iter_d  = iter_q + 1'b1;
        if (last_iter) state_d = S_FIXUP;
      end
      // acc is reused as the signed product register from here on
      S_FIXUP: begin
        acc_d   = neg_q ? neg2w(acc_q) : acc_q;
        state_d = S_DONE;
      end
      S_DONE: if (cdb_mul_ack) state_d = S_IDLE;
      default: ;
    endcase

    if (accept) begin
      state_d = S_BUSY;
      op_d    = mul_op;
      rob_d   = rob;
      arch_d  = arch_reg;
      phys_d  = phys_reg;
      ps1_d   = a;
      ps2_d   = b;
      mag_a_d = mag_of(a, sign_a);
      mag_b_d = mag_of(b, sign_b);
      neg_d   = (sign_a ^ sign_b) & (|a) & (|b);
      acc_d   = '0;
      iter_d  = '0;
    end

    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rob_q   <= '0;
      arch_q  <= '0;
      phys_q  <= '0;
      ps1_q   <= '0;
      ps2_q   <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rob_q   <= rob_d;
      arch_q  <= arch_d;
      phys_q  <= phys_d;
      ps1_q   <= ps1_d;
      ps2_q   <= ps2_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    mul_cdb_output = '0;
    if (state_q == S_DONE) begin
      mul_cdb_output.cdb_valid = 1'b1;
      mul_cdb_output.rob       = rob_q;
      mul_cdb_output.arch_reg  = arch_q;
      mul_cdb_output.phys_reg  = phys_q;
      mul_cdb_output.data      = XLEN'((op_q == MUL) ? acc_q[W-1:0] : acc_q[2*W-1:W]);
      mul_cdb_output.ps1_rdata = XLEN'(ps1_q);
      mul_cdb_output.ps2_rdata = XLEN'(ps2_q);
    end
  end

endmodule

// File: tb/tb_mul_iter_unit.sv
// Directed and model-checked bench for mul_iter_unit across BPC 1/2/4 and both early-term settings.
module tb_mul_iter_unit;
  import mul_iter_unit_pkg::*;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b0;
  logic [3:0]           sv    = '0;
  logic [3:0]           ack   = '0;
  logic [3:0]           rdy;
  logic                 flush = 1'b0;
  logic [1:0]           op    = '0;
  logic [31:0]          a     = '0;
  logic [31:0]          b     = '0;
  logic [4:0]           arch  = '0;
  logic [PR_WIDTH-1:0]  phys  = '0;
  logic [ROB_WIDTH-1:0] rob   = '0;
  cdb_t                 outp [4];
  int                   n_cmp = 0;
  int                   n_bad = 0;

  always #5 clk = ~clk;

  // dut0: BPC2/ET1, dut1: BPC2/ET0, dut2: BPC4/ET1, dut3: BPC1/ET1
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int BPC = (g == 2) ? 4 : ((g == 3) ? 1 : 2);
    localparam int ET  = (g == 1) ? 0 : 1;
    mul_iter_unit #(
      .OPERAND_WIDTH  (32),
      .BITS_PER_CYCLE (BPC),
      .EARLY_TERM     (ET)
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start_valid    (sv[g]),
      .start_ready    (rdy[g]),
      .mul_op         (op),
      .a              (a),
      .b              (b),
      .arch_reg       (arch),
      .phys_reg       (phys),
      .rob            (rob),
      .flush          (flush),
      .cdb_mul_ack    (ack[g]),
      .mul_cdb_output (outp[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] ex, ey, p;
    ex = (o == MULH || o == MULHSU) ? {{32{x[31]}}, x} : {32'b0, x};
    ey = (o == MULH) ? {{32{y[31]}}, y} : {32'b0, y};
    p  = ex * ey;
    return (o == MUL) ? p[31:0] : p[63:32];
  endfunction

  task automatic issue(input int d, input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                       input logic [4:0] tag);
    @(negedge clk);
    op = o; a = xa; b = xb; arch = tag; phys = PR_WIDTH'(tag + 1); rob = ROB_WIDTH'(tag);
    sv[d] = 1'b1;
    @(negedge clk);
    sv[d] = 1'b0;
    a = ~xa; b = ~xb;
  endtask

  task automatic wait_valid(input int d, output int cyc);
    cyc = 1;
    while (!outp[d].cdb_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!outp[d].cdb_valid) chk("timeout", 64'd0, 64'd1);
  endtask

  task automatic check_pkt(input int d, input string tag, input logic [31:0] exp,
                           input logic [31:0] xa, input logic [31:0] xb, input logic [4:0] t);
    chk({tag, "_data"}, {32'b0, outp[d].data}, {32'b0, exp});
    chk({tag, "_tags"}, {47'b0, outp[d].br_taken, outp[d].rob, outp[d].arch_reg, outp[d].phys_reg},
        {47'b0, 1'b0, ROB_WIDTH'(t), t, PR_WIDTH'(t + 1)});
    chk({tag, "_ops"}, {outp[d].ps1_rdata, outp[d].ps2_rdata}, {xa, xb});
  endtask

  task automatic ack_pkt(input int d, input string tag);
    ack[d] = 1'b1;
    @(negedge clk);
    ack[d] = 1'b0;
    chk({tag, "_drop"}, {63'b0, outp[d].cdb_valid}, 64'd0);
  endtask

  task automatic run_op(input int d, input string tag, input logic [1:0] o, input logic [31:0] xa,
                        input logic [31:0] xb, input logic [31:0] exp, input logic [4:0] t);
    int cyc;
    issue(d, o, xa, xb, t);
    wait_valid(d, cyc);
    check_pkt(d, tag, exp, xa, xb, t);
    ack_pkt(d, tag);
  endtask

  task automatic count_valid(input int d, input int ncyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (outp[d].cdb_valid) cnt++;
      @(negedge clk);
    end
  endtask

  logic [1:0]  dop [8];
  logic [31:0] da  [8];
  logic [31:0] db  [8];
  logic [31:0] dex [8];

  initial begin
    int cyc, cnt;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    dop[0] = MUL;    da[0] = 32'd7;         db[0] = 32'hFFFF_FFFD; dex[0] = 32'hFFFF_FFEB;
    dop[1] = MULH;   da[1] = 32'h8000_0000; db[1] = 32'h8000_0000; dex[1] = 32'h4000_0000;
    dop[2] = MULHSU; da[2] = 32'hFFFF_FFFF; db[2] = 32'hFFFF_FFFF; dex[2] = 32'hFFFF_FFFF;
    dop[3] = MULHU;  da[3] = 32'hFFFF_FFFF; db[3] = 32'hFFFF_FFFF; dex[3] = 32'hFFFF_FFFE;
    dop[4] = MUL;    da[4] = 32'hDEAD_BEEF; db[4] = 32'd0;         dex[4] = 32'd0;
    dop[5] = MULH;   da[5] = 32'hFFFF_FFFF; db[5] = 32'hFFFF_FFFF; dex[5] = 32'd0;
    dop[6] = MULHSU; da[6] = 32'h8000_0000; db[6] = 32'h8000_0000; dex[6] = 32'hC000_0000;
    dop[7] = MUL;    da[7] = 32'h1234_5678; db[7] = 32'h0000_0010; dex[7] = 32'h2345_6780;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_valid", {63'b0, outp[0].cdb_valid}, 64'd0);
    chk("rst_data", {32'b0, outp[0].data}, 64'd0);
    chk("rst_ready", {60'b0, rdy}, 64'hF);

    for (int d = 0; d < 4; d++)
      for (int i = 0; i < 8; i++)
        run_op(d, $sformatf("dir%0d_%0d", d, i), dop[i], da[i], db[i], dex[i], 5'(i + 3));

    // Latency with a single set multiplier bit
    issue(1, MUL, 32'd5, 32'd1, 5'd9);
    wait_valid(1, cyc);
    chk("lat_et0", 64'(cyc), 64'd18);
    check_pkt(1, "lat_et0", 32'd5, 32'd5, 32'd1, 5'd9);
    ack_pkt(1, "lat_et0");
    issue(0, MUL, 32'd5, 32'd1, 5'd10);
    wait_valid(0, cyc);
    chk("lat_et1", 64'(cyc), 64'd3);
    ack_pkt(0, "lat_et1");

    // Hold without ack, then back-to-back ack + issue
    issue(0, MUL, 32'd7, 32'hFFFF_FFFD, 5'd11);
    wait_valid(0, cyc);
    for (int i = 0; i < 10; i++) begin
      chk("hold_data", {32'b0, outp[0].data}, 64'hFFFF_FFEB);
      chk("hold_ready", {63'b0, rdy[0]}, 64'd0);
      @(negedge clk);
    end
    chk("hold_valid", {63'b0, outp[0].cdb_valid}, 64'd1);
    op = MUL; a = 32'd3; b = 32'd5; arch = 5'd12; phys = PR_WIDTH'(13); rob = ROB_WIDTH'(12);
    sv[0] = 1'b1; ack[0] = 1'b1;
    #1;
    chk("b2b_ready", {63'b0, rdy[0]}, 64'd1);
    @(negedge clk);
    sv[0] = 1'b0; ack[0] = 1'b0;
    chk("b2b_once", {63'b0, outp[0].cdb_valid}, 64'd0);
    wait_valid(0, cyc);
    check_pkt(0, "b2b", 32'd15, 32'd3, 32'd5, 5'd12);
    ack_pkt(0, "b2b");

    // Flush in BUSY
    issue(1, MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_ready", {63'b0, rdy[1]}, 64'd1);
    count_valid(1, 30, cnt);
    chk("flush_busy_none", 64'(cnt), 64'd0);
    run_op(1, "post_flush", MULH, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 5'd14);

    // Flush in DONE together with ack and a new issue
    issue(0, MUL, 32'd6, 32'd7, 5'd15);
    wait_valid(0, cyc);
    op = MUL; a = 32'd2; b = 32'd2;
    flush = 1'b1; ack[0] = 1'b1; sv[0] = 1'b1;
    @(negedge clk);
    flush = 1'b0; ack[0] = 1'b0; sv[0] = 1'b0;
    count_valid(0, 20, cnt);
    chk("flush_done_none", 64'(cnt), 64'd0);

    // Flush beats start in IDLE
    sv[0] = 1'b1; flush = 1'b1;
    @(negedge clk);
    sv[0] = 1'b0; flush = 1'b0;
    count_valid(0, 20, cnt);
    chk("flush_start_none", 64'(cnt), 64'd0);
    run_op(0, "post_flush2", MUL, 32'd6, 32'd7, 32'd42, 5'd16);

    // Asynchronous reset mid-BUSY and in DONE
    issue(0, MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy_valid", {63'b0, outp[0].cdb_valid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_valid(0, 20, cnt);
    chk("arst_busy_stale", 64'(cnt), 64'd0);
    issue(0, MUL, 32'd9, 32'd9, 5'd18);
    wait_valid(0, cyc);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_done_valid", {63'b0, outp[0].cdb_valid}, 64'd0);
    chk("arst_done_data", {32'b0, outp[0].data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_valid(0, 20, cnt);
    chk("arst_done_stale", 64'(cnt), 64'd0);
    run_op(0, "post_rst", MUL, 32'd9, 32'd9, 32'd81, 5'd19);

    // Random operations against the reference model
    for (int d = 0; d < 4; d++)
      for (int i = 0; i < 40; i++) begin
        ro = 2'($urandom_range(0, 3));
        ra = $urandom;
        rb = $urandom >> $urandom_range(0, 31);
        if (i % 7 == 0) ra = 32'h8000_0000;
        if (i % 5 == 0) rb = ~rb;
        run_op(d, $sformatf("rnd%0d_%0d", d, i), ro, ra, rb, ref_mul(ro, ra, rb), 5'(i));
      end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
